// File: rtl/issue_scoreboard_pkg.sv
// Shared dual-issue pipeline types: register index, slot geometry and scoreboard sizing.
package issue_scoreboard_pkg;

  localparam int REG_W        = 5;
  localparam int NUM_REGS     = 32;
  localparam int NUM_SLOTS    = 2;
  localparam int NUM_SRCS     = 2;
  localparam int MAX_INFLIGHT = 4;

  typedef logic [REG_W-1:0] reg_idx_t;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Issue-slot and writeback-port bundle shared by the issue stage and the scoreboard.
interface issue_scoreboard_if;
  import issue_scoreboard_pkg::*;

  logic     [NUM_SLOTS-1:0]               is_valid;
  reg_idx_t [NUM_SLOTS-1:0][NUM_SRCS-1:0] is_r_reg;
  reg_idx_t [NUM_SLOTS-1:0]               is_w_reg;
  logic     [NUM_SLOTS-1:0]               is_long;
  logic     [NUM_SLOTS-1:0]               is_fire;
  logic     [NUM_SLOTS-1:0]               wb_valid;
  reg_idx_t [NUM_SLOTS-1:0]               wb_reg;
  logic     [NUM_SLOTS-1:0]               wb_long;
  logic     [NUM_SLOTS-1:0]               stall;

  modport master (
    output is_valid, is_r_reg, is_w_reg, is_long, is_fire,
    output wb_valid, wb_reg, wb_long,
    input  stall
  );

  modport slave (
    input  is_valid, is_r_reg, is_w_reg, is_long, is_fire,
    input  wb_valid, wb_reg, wb_long,
    output stall
  );

endinterface

// File: rtl/issue_scoreboard_hazard.sv
// Combinational hazard check for one issue slot against the effective pending set.
module scoreboard_hazard
  import issue_scoreboard_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic                     valid_i,
  input  reg_idx_t [NUM_SRCS-1:0]  r_reg_i,
  input  reg_idx_t                 w_reg_i,
  input  logic                     is_long_i,
  input  logic                     budget_full_i,
  input  logic [NREGS-1:0]         pend_eff_i,
  output logic                     hazard_o
);

  logic [NUM_SRCS-1:0] src_hit;
  logic                dst_hit;

  // r0 is hard-wired zero and can never be awaiting a result
  for (genvar gi = 0; gi < NUM_SRCS; gi++) begin : g_src
    assign src_hit[gi] = (r_reg_i[gi] != '0) & pend_eff_i[r_reg_i[gi]];
  end

  assign dst_hit  = (w_reg_i != '0) & pend_eff_i[w_reg_i];
  assign hazard_o = valid_i & ((|src_hit) | dst_hit | (is_long_i & budget_full_i));

endmodule

// File: rtl/issue_scoreboard.sv
// Long-latency register scoreboard: pending bits, inflight budget and sticky protocol error.
module issue_scoreboard #(
  parameter int  NUM_REGS     = issue_scoreboard_pkg::NUM_REGS,
  parameter int  MAX_INFLIGHT = issue_scoreboard_pkg::MAX_INFLIGHT,
  parameter bit  WB_BYPASS    = 1'b1,
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  issue_scoreboard_if.slave    sb_if,
  output logic [NUM_REGS-1:0]  busy_o,
  output logic [CNT_W-1:0]     inflight_o,
  output logic                 err_o
);
  import issue_scoreboard_pkg::*;

  localparam logic [CNT_W:0] MAX_W = (CNT_W + 1)'(MAX_INFLIGHT);

  logic [NUM_REGS-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0]     inflight_q, inflight_d;
  logic                 err_q, err_d;

  logic [NUM_REGS-1:0]  clr, set, pend_eff;
  logic [NUM_SLOTS-1:0] long_fire, wb_long_v, wb_hit, wb_bad, hazard, budget_full;
  logic                 wb_dup;
  logic [CNT_W:0]       base_w, fire_w, hit_w, next_w;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    assign long_fire[gi] = sb_if.is_fire[gi] & sb_if.is_long[gi] & (sb_if.is_w_reg[gi] != '0);
    assign wb_long_v[gi] = sb_if.wb_valid[gi] & sb_if.wb_long[gi];
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    assign clr[gi] = (wb_long_v[0] & (sb_if.wb_reg[0] == REG_W'(gi)))
                   | (wb_long_v[1] & (sb_if.wb_reg[1] == REG_W'(gi)));
    assign set[gi] = (long_fire[0] & (sb_if.is_w_reg[0] == REG_W'(gi)))
                   | (long_fire[1] & (sb_if.is_w_reg[1] == REG_W'(gi)));
  end

  assign pend_eff = WB_BYPASS ? (pending_q & ~clr) : pending_q;

  // Slot 1 must leave room for a long op that slot 0 may issue alongside it
  assign budget_full[0] = ({1'b0, inflight_q} >= MAX_W);
  assign budget_full[1] = ({1'b0, inflight_q} + (CNT_W + 1)'(sb_if.is_long[0]) >= MAX_W);

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_hazard
    scoreboard_hazard #(.NREGS(NUM_REGS)) u_hazard (
      .valid_i       (sb_if.is_valid[gi]),
      .r_reg_i       (sb_if.is_r_reg[gi]),
      .w_reg_i       (sb_if.is_w_reg[gi]),
      .is_long_i     (sb_if.is_long[gi]),
      .budget_full_i (budget_full[gi]),
      .pend_eff_i    (pend_eff),
      .hazard_o      (hazard[gi])
    );
  end

  // In-order issue: slot 1 may never overtake a held slot 0
  assign sb_if.stall = {hazard[1] | hazard[0], hazard[0]};

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_wb
    assign wb_hit[gi] = wb_long_v[gi] & (sb_if.wb_reg[gi] != '0) & pending_q[sb_if.wb_reg[gi]];
    assign wb_bad[gi] = wb_long_v[gi] & ((sb_if.wb_reg[gi] == '0)
                      | (~pending_q[sb_if.wb_reg[gi]] & ~set[sb_if.wb_reg[gi]]));
  end

  // Two ports retiring the same register free only one budget slot
  assign wb_dup = wb_hit[0] & wb_hit[1] & (sb_if.wb_reg[0] == sb_if.wb_reg[1]);

  always_comb begin
    pending_d    = (pending_q & ~clr) | set;
    pending_d[0] = 1'b0;

    base_w = {1'b0, inflight_q};
    fire_w = (CNT_W + 1)'(popcount2(long_fire));
    hit_w  = (CNT_W + 1)'(popcount2({wb_hit[1] & ~wb_dup, wb_hit[0]}));
    next_w = base_w + fire_w;
    if (next_w < hit_w) begin
      next_w = '0;
    end else begin
      next_w = next_w - hit_w;
    end
    if (next_w > MAX_W) begin
      next_w = MAX_W;
    end
    inflight_d = next_w[CNT_W-1:0];

    err_d = err_q | (|wb_bad);

    if (flush_i) begin
      pending_d  = '0;
      inflight_d = '0;
      err_d      = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign busy_o     = pending_q;
  assign inflight_o = inflight_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scenario bench for issue_scoreboard: each row's expected outputs are queued and checked mid-cycle.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  typedef struct packed {
    logic       rst;
    logic       flush;
    logic [1:0] valid;
    reg_idx_t   r00, r01, r10, r11, w0, w1;
    logic [1:0] lng, fire, wbv;
    reg_idx_t   wb0, wb1;
    logic [1:0] wbl;
  } stim_t;

  typedef struct packed {
    logic [1:0]  stall;
    logic [31:0] busy;
    logic [2:0]  infl;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] busy;
  logic [2:0]  infl;
  logic        err;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  issue_scoreboard_if sb_if();

  issue_scoreboard #(
    .NUM_REGS     (32),
    .MAX_INFLIGHT (4),
    .WB_BYPASS    (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .sb_if      (sb_if.slave),
    .busy_o     (busy),
    .inflight_o (infl),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  function automatic stim_t st(input logic r, input logic f, input logic [1:0] v,
                               input int r00, input int r01, input int r10, input int r11,
                               input int w0, input int w1, input logic [1:0] lng,
                               input logic [1:0] fire, input logic [1:0] wbv,
                               input int wb0, input int wb1, input logic [1:0] wbl);
    stim_t s;
    s.rst = r;  s.flush = f;  s.valid = v;
    s.r00 = reg_idx_t'(r00);  s.r01 = reg_idx_t'(r01);
    s.r10 = reg_idx_t'(r10);  s.r11 = reg_idx_t'(r11);
    s.w0  = reg_idx_t'(w0);   s.w1  = reg_idx_t'(w1);
    s.lng = lng;  s.fire = fire;  s.wbv = wbv;
    s.wb0 = reg_idx_t'(wb0);  s.wb1 = reg_idx_t'(wb1);  s.wbl = wbl;
    return s;
  endfunction

  function automatic exp_t ex(input logic [1:0] s, input logic [31:0] b,
                              input logic [2:0] i, input logic e);
    exp_t x;
    x.stall = s;  x.busy = b;  x.infl = i;  x.err = e;
    return x;
  endfunction

  function automatic stim_t idle();
    return st(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
  endfunction

  task automatic drive(input stim_t s);
    @(negedge clk);
    rst                  = s.rst;
    flush                = s.flush;
    sb_if.is_valid       = s.valid;
    sb_if.is_r_reg[0][0] = s.r00;
    sb_if.is_r_reg[0][1] = s.r01;
    sb_if.is_r_reg[1][0] = s.r10;
    sb_if.is_r_reg[1][1] = s.r11;
    sb_if.is_w_reg[0]    = s.w0;
    sb_if.is_w_reg[1]    = s.w1;
    sb_if.is_long        = s.lng;
    sb_if.is_fire        = s.fire;
    sb_if.wb_valid       = s.wbv;
    sb_if.wb_reg[0]      = s.wb0;
    sb_if.wb_reg[1]      = s.wb1;
    sb_if.wb_long        = s.wbl;
  endtask

  task automatic test_reset();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(0, 0, 2'b01, 5, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00));
    e.push_back(ex(2'b00, 32'h0, 3'd0, 1'b0));
    s.push_back(st(0, 0, 2'b11, 5, 6, 7, 8, 9, 10, 2'b11, 2'b00, 2'b00, 0, 0, 2'b00));
    e.push_back(ex(2'b00, 32'h0, 3'd0, 1'b0));
    foreach (s[i]) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      #1;
      got  = ex(sb_if.stall, busy, infl, err);
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset[%0d] got stall=%b busy=%h infl=%0d err=%b, expected stall=%b busy=%h infl=%0d err=%b",
                 i, got.stall, got.busy, got.infl, got.err, want.stall, want.busy, want.infl, want.err);
      end else begin
        $display("ok reset[%0d] stall=%b busy=%h infl=%0d err=%b", i, got.stall, got.busy, got.infl, got.err);
      end
    end
  endtask

  task automatic test_raw();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(0, 0, 2'b01, 0, 0, 0, 0, 5, 0, 2'b01, 2'b01, 2'b00, 0, 0, 2'b00));
    e.push_back(ex(2'b00, 32'h0, 3'd0, 1'b0));
    s.push_back(st(0, 0, 2'b01, 5, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00));
    e.push_back(ex(2'b11, 32'h20, 3'd1, 1'b0));
    s.push_back(st(0, 0, 2'b10, 0, 0, 5, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00));
    e.push_back(ex(2'b10, 32'h20, 3'd1, 1'b0));
    s.push_back(st(0, 0, 2'b01, 5, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 5, 0, 2'b01));
    e.push_back(ex(2'b00, 32'h20, 3'd1, 1'b0));
    s.push_back(st(0, 0, 2'b01, 5, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00));
    e.push_back(ex(2'b00, 32'h0, 3'd0, 1'b0));
    foreach (s[i]) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      #1;
      got  = ex(sb_if.stall, busy, infl, err);
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL raw[%0d] got stall=%b busy=%h infl=%0d err=%b, expected stall=%b busy=%h infl=%0d err=%b",
                 i, got.stall, got.busy, got.infl, got.err, want.stall, want.busy, want.infl, want.err);
      end else begin
        $display("ok raw[%0d] stall=%b busy=%h infl=%0d err=%b", i, got.stall, got.busy, got.infl, got.err);
      end
    end
  endtask

  task automatic test_waw();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(0, 0, 2'b10, 0, 0, 0, 0, 0, 7, 2'b10, 2'b10, 2'b00, 0, 0, 2'b00));
    e.push_back(ex(2'b00, 32'h0, 3'd0, 1'b0));
    s.push_back(st(0, 0, 2'b11, 1, 2, 0, 0, 3, 7, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00));
    e.push_back(ex(2'b10, 32'h80, 3'd1, 1'b0));
    s.push_back(st(0, 0, 2'b11, 7, 0, 0, 0, 0, 8, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00));
    e.push_back(ex(2'b11, 32'h80, 3'd1, 1'b0));
    s.push_back(st(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 7, 2'b10));
    e.push_back(ex(2'b00, 32'h80, 3'd1, 1'b0));
    s.push_back(idle());
    e.push_back(ex(2'b00, 32'h0, 3'd0, 1'b0));
    foreach (s[i]) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      #1;
      got  = ex(sb_if.stall, busy, infl, err);
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL waw[%0d] got stall=%b busy=%h infl=%0d err=%b, expected stall=%b busy=%h infl=%0d err=%b",
                 i, got.stall, got.busy, got.infl, got.err, want.stall, want.busy, want.infl, want.err);
      end else begin
        $display("ok waw[%0d] stall=%b busy=%h infl=%0d err=%b", i, got.stall, got.busy, got.infl, got.err);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(0, 0, 2'b01, 0, 0, 0, 0, 5, 0, 2'b01, 2'b01, 2'b00, 0, 0, 2'b00));
    e.push_back(ex(2'b00, 32'h0, 3'd0, 1'b0));
    // re-issue to r5 in the same cycle its previous producer writes back: set wins
    s.push_back(st(0, 0, 2'b01, 0, 0, 0, 0, 5, 0, 2'b01, 2'b01, 2'b01, 5, 0, 2'b01));
    e.push_back(ex(2'b00, 32'h20, 3'd1, 1'b0));
    s.push_back(idle());
    e.push_back(ex(2'b00, 32'h20, 3'd1, 1'b0));
    s.push_back(st(0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b01, 5, 0, 2'b01));
    e.push_back(ex(2'b00, 32'h20, 3'd1, 1'b0));
    s.push_back(idle());
    e.push_back(ex(2'b00, 32'h0, 3'd0, 1'b0));
    foreach (s[i]) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      #1;
      got  = ex(sb_if.stall, busy, infl, err);
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL b2b[%0d] got stall=%b busy=%h infl=%0d err=%b, expected stall=%b busy=%h infl=%0d err=%b",
                 i, got.stall, got.busy, got.infl, got.err, want.stall, want.busy, want.infl, want.err);
      end else begin
        $display("ok b2b[%0d] stall=%b busy=%h infl=%0d err=%b", i, got.stall, got.busy, got.infl, got.err);
      end
    end
  endtask

  task automatic test_budget();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(0, 0, 2'b11, 0, 0, 0, 0, 1, 2, 2'b11, 2'b11, 2'b00, 0, 0, 2'b00));
    e.push_back(ex(2'b00, 32'h0, 3'd0, 1'b0));
    s.push_back(st(0, 0, 2'b11, 0, 0, 0, 0, 3, 4, 2'b11, 2'b11, 2'b00, 0, 0, 2'b00));
    e.push_back(ex(2'b00, 32'h6, 3'd2, 1'b0));
    s.push_back(st(0, 0, 2'b01, 0, 0, 0, 0, 9, 0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00));
    e.push_back(ex(2'b11, 32'h1E, 3'd4, 1'b0));
    s.push_back(st(0, 0, 2'b01, 10, 11, 0, 0, 9, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00));
    e.push_back(ex(2'b00, 32'h1E, 3'd4, 1'b0));
    s.push_back(st(0, 0, 2'b01, 0, 0, 0, 0, 9, 0, 2'b01, 2'b00, 2'b01, 2, 0, 2'b01));
    e.push_back(ex(2'b11, 32'h1E, 3'd4, 1'b0));
    s.push_back(st(0, 0, 2'b11, 0, 0, 0, 0, 9, 22, 2'b11, 2'b01, 2'b00, 0, 0, 2'b00));
    e.push_back(ex(2'b10, 32'h1A, 3'd3, 1'b0));
    s.push_back(st(0, 0, 2'b11, 0, 0, 0, 0, 20, 21, 2'b11, 2'b00, 2'b00, 0, 0, 2'b00));
    e.push_back(ex(2'b11, 32'h21A, 3'd4, 1'b0));
    foreach (s[i]) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      #1;
      got  = ex(sb_if.stall, busy, infl, err);
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL budget[%0d] got stall=%b busy=%h infl=%0d err=%b, expected stall=%b busy=%h infl=%0d err=%b",
                 i, got.stall, got.busy, got.infl, got.err, want.stall, want.busy, want.infl, want.err);
      end else begin
        $display("ok budget[%0d] stall=%b busy=%h infl=%0d err=%b", i, got.stall, got.busy, got.infl, got.err);
      end
    end
  endtask

  task automatic test_flush();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(0, 1, 2'b01, 0, 0, 0, 0, 10, 0, 2'b01, 2'b01, 2'b01, 12, 0, 2'b01));
    e.push_back(ex(2'b11, 32'h21A, 3'd4, 1'b0));
    s.push_back(idle());
    e.push_back(ex(2'b00, 32'h0, 3'd0, 1'b0));
    foreach (s[i]) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      #1;
      got  = ex(sb_if.stall, busy, infl, err);
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL flush[%0d] got stall=%b busy=%h infl=%0d err=%b, expected stall=%b busy=%h infl=%0d err=%b",
                 i, got.stall, got.busy, got.infl, got.err, want.stall, want.busy, want.infl, want.err);
      end else begin
        $display("ok flush[%0d] stall=%b busy=%h infl=%0d err=%b", i, got.stall, got.busy, got.infl, got.err);
      end
    end
  endtask

  task automatic test_err();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 12, 0, 2'b01));
    e.push_back(ex(2'b00, 32'h0, 3'd0, 1'b0));
    s.push_back(st(0, 0, 2'b01, 0, 0, 0, 0, 6, 0, 2'b01, 2'b01, 2'b00, 0, 0, 2'b00));
    e.push_back(ex(2'b00, 32'h0, 3'd0, 1'b1));
    s.push_back(st(1, 0, 2'b01, 0, 0, 0, 0, 7, 0, 2'b01, 2'b01, 2'b00, 0, 0, 2'b00));
    e.push_back(ex(2'b00, 32'h40, 3'd1, 1'b1));
    s.push_back(idle());
    e.push_back(ex(2'b00, 32'h0, 3'd0, 1'b0));
    s.push_back(st(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 0, 2'b10));
    e.push_back(ex(2'b00, 32'h0, 3'd0, 1'b0));
    s.push_back(idle());
    e.push_back(ex(2'b00, 32'h0, 3'd0, 1'b1));
    foreach (s[i]) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      #1;
      got  = ex(sb_if.stall, busy, infl, err);
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL err[%0d] got stall=%b busy=%h infl=%0d err=%b, expected stall=%b busy=%h infl=%0d err=%b",
                 i, got.stall, got.busy, got.infl, got.err, want.stall, want.busy, want.infl, want.err);
      end else begin
        $display("ok err[%0d] stall=%b busy=%h infl=%0d err=%b", i, got.stall, got.busy, got.infl, got.err);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    sb_if.is_valid = '0;
    sb_if.is_r_reg = '0;
    sb_if.is_w_reg = '0;
    sb_if.is_long  = '0;
    sb_if.is_fire  = '0;
    sb_if.wb_valid = '0;
    sb_if.wb_reg   = '0;
    sb_if.wb_long  = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_raw();
    test_waw();
    test_back_to_back();
    test_budget();
    test_flush();
    test_err();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain left=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
